// File: rtl/vec_serial_ram_pkg.sv
// Shared widths and vector types for the lane-serial vector scratch RAM.
// DISPLAY_PORT_EN (optional macro) adds a read-only display port to the RAM.
package vec_serial_pkg;

    localparam int ELEM_W    = 9;
    localparam int LANES     = 9;
    localparam int ADDR_W    = 32;
    localparam int VEC_DEPTH = 910;
    localparam int DISP_AW   = 13;
    localparam int RAM_DEPTH = VEC_DEPTH * LANES;
    localparam int RAM_AW    = 13;
    localparam int PH_W      = 4;
    localparam int IDX_W     = 10;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef elem_t vec_t [LANES];
    typedef logic [PH_W-1:0] phase_t;

    // idx*9 + ph built from a shift and adds so no multiplier is inferred.
    function automatic logic [RAM_AW-1:0] elem_addr(input logic [IDX_W-1:0] idx,
                                                    input phase_t ph);
        logic [RAM_AW-1:0] sum;
        sum = {idx, 3'b000} + {3'b000, idx} + {9'b0, ph};
        return sum;
    endfunction

endpackage

// File: rtl/vec_serial_ram_if.sv
// Vector bus between the MEM stage (master) and the serial vector RAM (slave).
// The display port members exist only when DISPLAY_PORT_EN is defined.
interface vec_serial_ram_if;
    import vec_serial_pkg::*;

    logic [ADDR_W-1:0] addr_in;
    logic              we_in;
    vec_t              wdata;
    vec_t              rdata;
    logic              frame_start;
`ifdef DISPLAY_PORT_EN
    logic [DISP_AW-1:0] disp_addr;
    elem_t              disp_q;

    modport master (output addr_in, we_in, wdata, disp_addr,
                    input  rdata, frame_start, disp_q);
    modport slave  (input  addr_in, we_in, wdata, disp_addr,
                    output rdata, frame_start, disp_q);
`else
    modport master (output addr_in, we_in, wdata,
                    input  rdata, frame_start);
    modport slave  (input  addr_in, we_in, wdata,
                    output rdata, frame_start);
`endif

endinterface

// File: rtl/vec_serial_ram_mem.sv
// Scalar element RAM with registered read (old data on read-during-write).
// DISPLAY_PORT_EN adds a second, read-only port b on the same clock.
module vec_serial_ram_mem import vec_serial_pkg::*; (
    input  logic              clk,
    input  logic              a_we,
    input  logic [RAM_AW-1:0] a_addr,
    input  elem_t             a_wdata,
    output elem_t             a_q
`ifdef DISPLAY_PORT_EN
    ,
    input  logic [DISP_AW-1:0] b_addr,
    output elem_t              b_q
`endif
);

    localparam logic [RAM_AW-1:0] LAST_WORD = RAM_AW'(RAM_DEPTH - 1);

    // Contents power up cleared and are deliberately untouched by reset.
    elem_t mem [RAM_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
        a_q <= mem[a_addr];
    end

`ifdef DISPLAY_PORT_EN
    always_ff @(posedge clk) begin
        b_q <= (b_addr <= LAST_WORD) ? mem[b_addr] : '0;
    end
`endif

endmodule

// File: rtl/vec_serial_ram.sv
// Vector scratch RAM: serialises 9-lane vectors over 9 fast-clock phases into a
// scalar RAM and reassembles the read lanes. DISPLAY_PORT_EN enables disp_addr/disp_q.
module vec_serial_ram import vec_serial_pkg::*; (
    input  logic           clk,
    input  logic           rst_n,
    vec_serial_ram_if.slave bus
);

    localparam phase_t            LAST_PH   = phase_t'(LANES - 1);
    localparam logic [ADDR_W-3:0] DEPTH_IDX = ADDR_W'(VEC_DEPTH) >> 0;

    phase_t            ph_q, ph_d;
    logic [ADDR_W-3:0] frame_idx_q, frame_idx_d;
    logic              frame_we_q, frame_we_d;
    vec_t              frame_wdata_q, frame_wdata_d;
    elem_t             shadow_q [LANES-1];
    elem_t             shadow_d [LANES-1];
    vec_t              rdata_q, rdata_d;
    logic              rd_ok_q, rd_ok_d;

    logic              in_range;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    elem_t             ram_wdata;
    elem_t             ram_q;
    elem_t             lane_q;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^bus.addr_in[1:0];

    // Out-of-range frames park the RAM on word 0 with writes blocked; rd_ok_q
    // tracks the registered read so those lanes come back as zero.
    always_comb begin
        in_range  = (frame_idx_q < DEPTH_IDX);
        ram_addr  = in_range ? elem_addr(frame_idx_q[IDX_W-1:0], ph_q) : '0;
        ram_we    = frame_we_q && in_range && rst_n;
        ram_wdata = frame_wdata_q[ph_q];
        lane_q    = rd_ok_q ? ram_q : '0;
    end

    always_comb begin
        ph_d          = (ph_q == LAST_PH) ? '0 : ph_q + phase_t'(1);
        frame_idx_d   = frame_idx_q;
        frame_we_d    = frame_we_q;
        frame_wdata_d = frame_wdata_q;
        shadow_d      = shadow_q;
        rdata_d       = rdata_q;
        rd_ok_d       = in_range;

        if (ph_q == LAST_PH) begin
            frame_idx_d   = bus.addr_in[ADDR_W-1:2];
            frame_we_d    = bus.we_in;
            frame_wdata_d = bus.wdata;
        end

        // Lane L's read arrives one phase late; lane 8 lands in the next frame.
        for (int l = 0; l < LANES - 1; l++) begin
            if (ph_q == phase_t'(l + 1)) begin
                shadow_d[l] = lane_q;
            end
        end

        if (ph_q == '0) begin
            for (int l = 0; l < LANES - 1; l++) begin
                rdata_d[l] = shadow_q[l];
            end
            rdata_d[LANES-1] = lane_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph_q          <= '0;
            frame_idx_q   <= '0;
            frame_we_q    <= 1'b0;
            frame_wdata_q <= '{default: '0};
            shadow_q      <= '{default: '0};
            rdata_q       <= '{default: '0};
            rd_ok_q       <= 1'b0;
        end else begin
            ph_q          <= ph_d;
            frame_idx_q   <= frame_idx_d;
            frame_we_q    <= frame_we_d;
            frame_wdata_q <= frame_wdata_d;
            shadow_q      <= shadow_d;
            rdata_q       <= rdata_d;
            rd_ok_q       <= rd_ok_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.frame_start = (ph_q == '0);

    vec_serial_ram_mem u_mem (
        .clk     (clk),
        .a_we    (ram_we),
        .a_addr  (ram_addr),
        .a_wdata (ram_wdata),
        .a_q     (ram_q)
`ifdef DISPLAY_PORT_EN
        ,
        .b_addr  (bus.disp_addr),
        .b_q     (bus.disp_q)
`endif
    );

endmodule

// File: tb/tb_vec_serial_ram.sv
// Randomised bench for vec_serial_ram against a frame-level memory model.
// Display port checks are compiled in only when DISPLAY_PORT_EN is defined.
module tb_vec_serial_ram;
    import vec_serial_pkg::*;

    localparam int VW = LANES * ELEM_W;

    logic clk = 1'b0;
    logic rst_n;

    vec_serial_ram_if bus ();

    vec_serial_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cur_frame = 0;
    elem_t       model_mem [RAM_DEPTH];
    logic [VW-1:0] exp_rdata [256];
    int          wr_base [256];

    function automatic logic [VW-1:0] pack(input vec_t v);
        logic [VW-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*ELEM_W +: ELEM_W] = v[l];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                               input logic [VW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic rampVec(input int base, input int step, output vec_t v);
        for (int l = 0; l < LANES; l++) begin
            v[l] = elem_t'(base + step * l);
        end
    endtask

    task automatic randVec(output vec_t v);
        for (int l = 0; l < LANES; l++) begin
            v[l] = elem_t'($urandom_range(0, 511));
        end
    endtask

    // A frame reads the whole vector as it stood before the frame, then writes it.
    task automatic modelFrame(input int frame, input logic [31:0] addr, input logic we,
                              input vec_t wd);
        longint unsigned idx;
        vec_t rd;
        int base;
        idx  = longint'(addr) >> 2;
        base = -1;
        if (idx < VEC_DEPTH) begin
            base = int'(idx) * LANES;
        end
        for (int l = 0; l < LANES; l++) begin
            rd[l] = (base >= 0) ? model_mem[base + l] : elem_t'(0);
        end
        exp_rdata[frame] = pack(rd);
        wr_base[frame] = -1;
        if (base >= 0 && we) begin
            for (int l = 0; l < LANES; l++) begin
                model_mem[base + l] = wd[l];
            end
            wr_base[frame] = base;
        end
    endtask

    // Entered at the phase-0 negedge; next frame's inputs change mid-frame at phase 4.
    task automatic applyStimulus(input logic [31:0] addr, input logic we, input vec_t wd);
`ifdef DISPLAY_PORT_EN
        int disp_a;
`endif
        checkOutput("frame_start_p0", VW'(bus.frame_start), VW'(1));
        if (cur_frame >= 2) begin
            checkOutput($sformatf("rdata_f%0d", cur_frame - 2), pack(bus.rdata),
                        exp_rdata[cur_frame - 2]);
        end
`ifdef DISPLAY_PORT_EN
        disp_a = 0;
`endif
        for (int p = 1; p < LANES; p++) begin
            @(negedge clk);
            checkOutput("frame_start", VW'(bus.frame_start), '0);
`ifdef DISPLAY_PORT_EN
            if (p == 2) begin
                disp_a = (cur_frame % 2 == 0) ? 36 : $urandom_range(0, RAM_DEPTH - 1);
                bus.disp_addr = DISP_AW'(disp_a);
            end
            if (p == 3) begin
                if (wr_base[cur_frame] < 0 || disp_a < wr_base[cur_frame] ||
                    disp_a >= wr_base[cur_frame] + LANES) begin
                    checkOutput($sformatf("disp_q_%0d", disp_a), VW'(bus.disp_q),
                                VW'(model_mem[disp_a]));
                end
            end
`endif
            if (p == 4) begin
                bus.addr_in = addr;
                bus.we_in   = we;
                bus.wdata   = wd;
                modelFrame(cur_frame + 1, addr, we, wd);
            end
        end
        @(negedge clk);
        cur_frame++;
    endtask

    initial begin
        vec_t zero_v;
        vec_t v;
        vec_t va;
        vec_t vb;
        logic [31:0] a;

        zero_v = '{default: '0};
        for (int i = 0; i < RAM_DEPTH; i++) begin
            model_mem[i] = '0;
        end
        rst_n       = 1'b0;
        bus.addr_in = '0;
        bus.we_in   = 1'b0;
        bus.wdata   = zero_v;
`ifdef DISPLAY_PORT_EN
        bus.disp_addr = '0;
`endif
        modelFrame(0, 32'd0, 1'b0, zero_v);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_rdata", pack(bus.rdata), '0);
        checkOutput("reset_frame_start", VW'(bus.frame_start), VW'(1));

        applyStimulus(32'd4, 1'b0, zero_v);
        applyStimulus(32'd4, 1'b0, zero_v);
        rampVec(21, 1, v);
        applyStimulus(32'd4, 1'b1, v);
        applyStimulus(32'd4, 1'b0, zero_v);
        rampVec(10, 10, v);
        applyStimulus(32'd2564, 1'b1, v);
        applyStimulus(32'd2564, 1'b0, zero_v);
        applyStimulus(32'd4, 1'b0, zero_v);
        applyStimulus(32'd8, 1'b0, zero_v);
        applyStimulus(32'd2568, 1'b0, zero_v);
        randVec(va);
        randVec(vb);
        applyStimulus(32'd13, 1'b1, va);
        applyStimulus(32'd12, 1'b1, vb);
        applyStimulus(32'd12, 1'b0, zero_v);
        randVec(v);
        applyStimulus(32'd3640, 1'b1, v);
        applyStimulus(32'd3640, 1'b0, zero_v);
        applyStimulus(32'd3636, 1'b0, zero_v);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom();
            end else if ($urandom_range(0, 1) == 0) begin
                a = 32'($urandom_range(0, 4) * 4 + $urandom_range(0, 3));
            end else begin
                a = 32'($urandom_range(905, 912) * 4 + $urandom_range(0, 3));
            end
            randVec(v);
            applyStimulus(a, 1'($urandom_range(0, 1)), v);
        end

        repeat (3) applyStimulus(32'd0, 1'b0, zero_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
